// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: data-memory port arbiter owning SP; PUSH/POP, CALL/RET and interrupt PC save/restore
// Optional build macro SP_BOUNDS_CHECK_EN suppresses stack overflow/underflow and pulses stack_fault.
module stack_mem_ctrl #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] SP_RESET   = 16'h07FF,
    parameter logic [ADDR_W-1:0] SP_LIMIT   = 16'h0400,
    parameter logic [31:0]       INT_VECTOR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              push,
    input  logic              pop,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              int_req,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [15:0]       ex_wdata,
    input  logic [31:0]       pc_in,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              stall,
    output logic              wb_bubble,
    output logic [31:0]       pc_out,
    output logic              pc_load,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_fault
);
    typedef enum logic [2:0] {IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI} state_t;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);
`ifdef SP_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       lo_q, lo_d;
    logic              int_q, int_d;
    logic              f_push1, f_push2, f_pop1, f_pop2, ldst, seq_push;
    assign f_push1  = CHK && (int'(sp_q) - 1 < int'(SP_LIMIT));
    assign f_push2  = CHK && (int'(sp_q) - 2 < int'(SP_LIMIT));
    assign f_pop1   = CHK && (int'(sp_q) + 1 > int'(SP_RESET));
    assign f_pop2   = CHK && (int'(sp_q) + 2 > int'(SP_RESET));
    assign ldst     = mem_read | mem_write;
    assign seq_push = int_req | (call_req & ~ret_req);
    assign sp_out   = sp_q;
    // State, SP, low return word and interrupt flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= SP_RESET;
            lo_q    <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            lo_q    <= lo_d;
            int_q   <= int_d;
        end
    end
    // Request arbitration, sequencing and memory-port drive
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        lo_d        = lo_q;
        int_d       = int_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        stall       = 1'b0;
        wb_bubble   = 1'b0;
        pc_out      = '0;
        pc_load     = 1'b0;
        stack_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (seq_push) begin
                    if (f_push2) begin
                        stack_fault = 1'b1;
                        stall       = ret_req | push | pop | ldst;
                    end else begin
                        state_d   = PUSH_HI;
                        int_d     = int_req;
                        stall     = 1'b1;
                        wb_bubble = 1'b1;
                    end
                end else if (ret_req) begin
                    if (f_pop2) begin
                        stack_fault = 1'b1;
                        stall       = call_req | push | pop | ldst;
                    end else begin
                        state_d   = POP_LO;
                        stall     = 1'b1;
                        wb_bubble = 1'b1;
                    end
                end else if (push) begin
                    stall       = pop | ldst;
                    stack_fault = f_push1;
                    mem_addr    = sp_q;
                    mem_wdata   = ex_wdata;
                    mem_we      = !f_push1;
                    sp_d        = f_push1 ? sp_q : sp_q - ONE;
                end else if (pop) begin
                    stall       = ldst;
                    stack_fault = f_pop1;
                    mem_addr    = sp_q + ONE;
                    mem_re      = !f_pop1;
                    sp_d        = f_pop1 ? sp_q : sp_q + ONE;
                end else begin
                    mem_addr  = ex_addr;
                    mem_wdata = ex_wdata;
                    mem_we    = mem_write;
                    mem_re    = mem_read;
                end
            end
            PUSH_HI: begin
                mem_addr  = sp_q;
                mem_wdata = pc_in[31:16];
                mem_we    = 1'b1;
                stall     = 1'b1;
                wb_bubble = 1'b1;
                state_d   = PUSH_LO;
            end
            PUSH_LO: begin
                mem_addr  = sp_q - ONE;
                mem_wdata = pc_in[15:0];
                mem_we    = 1'b1;
                wb_bubble = 1'b1;
                pc_load   = int_q;
                pc_out    = int_q ? INT_VECTOR : '0;
                sp_d      = sp_q - TWO;
                state_d   = IDLE;
            end
            POP_LO: begin
                mem_addr  = sp_q + ONE;
                mem_re    = 1'b1;
                lo_d      = mem_rdata;
                stall     = 1'b1;
                wb_bubble = 1'b1;
                state_d   = POP_HI;
            end
            POP_HI: begin
                mem_addr  = sp_q + TWO;
                mem_re    = 1'b1;
                wb_bubble = 1'b1;
                pc_out    = {mem_rdata, lo_q};
                pc_load   = 1'b1;
                sp_d      = sp_q + TWO;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb_stack_mem_ctrl: directed checks of stack_mem_ctrl against a behavioural memory
module tb_stack_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, push, pop, call_req, ret_req, int_req;
    logic [15:0] ex_addr, ex_wdata, mem_rdata, mem_addr, mem_wdata, sp_out;
    logic [31:0] pc_in, pc_out;
    logic        mem_we, mem_re, stall, wb_bubble, pc_load, stack_fault;
    logic [15:0] mem [0:65535];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    stack_mem_ctrl #(.INT_VECTOR(32'h0000_0200)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .push(push), .pop(pop), .call_req(call_req), .ret_req(ret_req),
        .int_req(int_req), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .pc_in(pc_in),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .stall(stall), .wb_bubble(wb_bubble),
        .pc_out(pc_out), .pc_load(pc_load), .sp_out(sp_out), .stack_fault(stack_fault)
    );

    assign mem_rdata = mem_re ? mem[mem_addr] : 16'h0;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {mem_read, mem_write, push, pop, call_req, ret_req, int_req} = '0;
        ex_addr = '0; ex_wdata = '0; pc_in = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_sp", sp_out, 16'h07FF);
        chk("rst_stall", stall, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_pcload", pc_load, 0);
        chk("rst_fault", stack_fault, 0);
        rst = 1'b0;
        push = 1'b1; ex_wdata = 16'hABCD; #1;
        chk("push_we", mem_we, 1);
        chk("push_addr", mem_addr, 16'h07FF);
        chk("push_data", mem_wdata, 16'hABCD);
        chk("push_stall", stall, 0);
        tick(); push = 1'b0;
        chk("push_sp", sp_out, 16'h07FE);
        chk("push_mem", mem[16'h07FF], 16'hABCD);
        pop = 1'b1; #1;
        chk("pop_re", mem_re, 1);
        chk("pop_addr", mem_addr, 16'h07FF);
        tick(); pop = 1'b0;
        chk("pop_sp", sp_out, 16'h07FF);
        call_req = 1'b1; pc_in = 32'h0001_0020; #1;
        chk("call_idle_we", mem_we, 0);
        tick();
        chk("call_hi_we", mem_we, 1);
        chk("call_hi_addr", mem_addr, 16'h07FF);
        chk("call_hi_data", mem_wdata, 16'h0001);
        chk("call_hi_stall", stall, 1);
        chk("call_hi_bubble", wb_bubble, 1);
        tick();
        chk("call_lo_addr", mem_addr, 16'h07FE);
        chk("call_lo_data", mem_wdata, 16'h0020);
        chk("call_lo_stall", stall, 0);
        chk("call_lo_bubble", wb_bubble, 1);
        chk("call_lo_pcload", pc_load, 0);
        tick(); call_req = 1'b0;
        chk("call_sp", sp_out, 16'h07FD);
        chk("call_mem_hi", mem[16'h07FF], 16'h0001);
        chk("call_mem_lo", mem[16'h07FE], 16'h0020);
        ret_req = 1'b1; #1;
        chk("ret_idle_pcload", pc_load, 0);
        tick();
        chk("ret_lo_addr", mem_addr, 16'h07FE);
        chk("ret_lo_stall", stall, 1);
        chk("ret_lo_bubble", wb_bubble, 1);
        tick();
        chk("ret_hi_addr", mem_addr, 16'h07FF);
        chk("ret_hi_pcload", pc_load, 1);
        chk("ret_hi_pc", pc_out, 32'h0001_0020);
        chk("ret_hi_bubble", wb_bubble, 1);
        tick(); ret_req = 1'b0; #1;
        chk("ret_sp", sp_out, 16'h07FF);
        chk("ret_done_pcload", pc_load, 0);
        int_req = 1'b1; mem_write = 1'b1; ex_addr = 16'h0100; ex_wdata = 16'h5555;
        pc_in = 32'h1234_5678; #1;
        chk("int_idle_we", mem_we, 0);
        chk("int_idle_stall", stall, 1);
        tick();
        chk("int_hi_addr", mem_addr, 16'h07FF);
        chk("int_hi_data", mem_wdata, 16'h1234);
        tick();
        chk("int_lo_addr", mem_addr, 16'h07FE);
        chk("int_lo_data", mem_wdata, 16'h5678);
        chk("int_lo_pcload", pc_load, 1);
        chk("int_lo_pc", pc_out, 32'h0000_0200);
        tick(); int_req = 1'b0; #1;
        chk("held_st_we", mem_we, 1);
        chk("held_st_addr", mem_addr, 16'h0100);
        chk("held_st_stall", stall, 0);
        tick(); mem_write = 1'b0;
        chk("held_st_mem", mem[16'h0100], 16'h5555);
        chk("int_sp", sp_out, 16'h07FD);
        mem_read = 1'b1; #1;
        chk("ld_re", mem_re, 1);
        chk("ld_addr", mem_addr, 16'h0100);
        chk("ld_we", mem_we, 0);
        tick(); mem_read = 1'b0;
        chk("ld_sp", sp_out, 16'h07FD);
        ret_req = 1'b1;
        tick();
        chk("rstseq_lo_stall", stall, 1);
        rst = 1'b1;
        tick(); rst = 1'b0; ret_req = 1'b0; #1;
        chk("rstseq_sp", sp_out, 16'h07FF);
        chk("rstseq_pcload", pc_load, 0);
        chk("rstseq_stall", stall, 0);
        tick();
        chk("rstseq_pcload2", pc_load, 0);
        pop = 1'b1; #1;
`ifdef SP_BOUNDS_CHECK_EN
        chk("uf_fault", stack_fault, 1);
        chk("uf_re", mem_re, 0);
        tick(); pop = 1'b0;
        chk("uf_sp", sp_out, 16'h07FF);
`else
        chk("uf_fault", stack_fault, 0);
        chk("uf_addr", mem_addr, 16'h0800);
        tick(); pop = 1'b0;
        chk("uf_sp", sp_out, 16'h0800);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
